// File: rtl/demux_stream_router.sv
// demux_stream_router: registered 1-to-N stream demux with a 2-entry FIFO per channel
module demux_stream_router #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    err_sel,
    output logic [7:0]              drop_cnt
);
    logic             sel_ok;
    logic             accept;
    logic [N_OUT-1:0] full;

    assign sel_ok   = int'(in_sel) < N_OUT;
    assign in_ready = sel_ok ? ~full[in_sel] : 1'b1;
    assign accept   = in_valid & in_ready;

    genvar k;
    generate
        for (k = 0; k < N_OUT; k++) begin : g_ch
            logic [1:0]        cnt;
            logic [DATA_W-1:0] head;
            logic [DATA_W-1:0] tail;
            logic              push;
            logic              pop;
            assign push    = accept & sel_ok & (in_sel == SEL_W'(k));
            assign pop     = out_valid[k] & out_ready[k];
            assign full[k] = cnt == 2'd2;
            assign out_valid[k] = cnt != 2'd0;
            assign out_data[k*DATA_W +: DATA_W] = head;
            // Channel FIFO: a push lands in head when it is free or being vacated, else in tail
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt  <= 2'd0;
                    head <= '0;
                    tail <= '0;
                end else begin
                    if (push && (cnt == 2'd0 || pop))
                        head <= in_data;
                    else if (pop)
                        head <= tail;
                    if (push && !pop && cnt == 2'd1)
                        tail <= in_data;
                    cnt <= cnt + 2'(push) - 2'(pop);
                end
            end
        end
    endgenerate

    // Out-of-range beats are swallowed: flag them next cycle and count with saturation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            err_sel <= accept & ~sel_ok;
            if (accept && !sel_ok && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
